// File: rtl/pixgen_pkg.sv
// Shared types, reset defaults and coordinate saturation for the viewport coordinate generator.
package pixgen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int          PIX_DEF_ORIGIN_RE = -320;
    localparam int          PIX_DEF_ORIGIN_IM = 240;
    localparam int unsigned PIX_DEF_STEP      = 1;

    // Accumulators are sign-extended to this width before clamping so one function serves any ACC_W.
    localparam int unsigned SAT_W = 64;

    // Clamp a wide signed accumulator into the signed coord_w-bit range.
    function automatic logic signed [SAT_W-1:0] sat_coord(input logic signed [SAT_W-1:0] acc,
                                                          input int unsigned coord_w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = $signed((64'd1 << (coord_w - 32'd1)) - 64'd1);
        lo = ~hi;
        if (acc > hi) begin
            return hi;
        end
        if (acc < lo) begin
            return lo;
        end
        return acc;
    endfunction

endpackage

// File: rtl/coord_accum.sv
// One axis of the raster walk: load an origin, step it by +/-step per beat, present it saturated.
module coord_accum
    import pixgen_pkg::*;
#(
    parameter int unsigned        COORD_W  = 16,
    parameter int unsigned        ACC_W    = 27,
    parameter bit                 SUBTRACT = 1'b0,
    parameter logic [COORD_W-1:0] RST_VAL  = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               step_en_i,
    input  logic [COORD_W-1:0] load_val_i,
    input  logic [COORD_W-1:0] step_i,
    output logic [COORD_W-1:0] z_o
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] step_ext;

    // Step is unsigned, so it is zero-extended; the origin is signed and sign-extended.
    always_comb begin
        step_ext = $signed(ACC_W'(step_i));
        acc_d    = acc_q;
        if (load_i) begin
            acc_d = ACC_W'($signed(load_val_i));
        end else if (step_en_i) begin
            acc_d = SUBTRACT ? (acc_q - step_ext) : (acc_q + step_ext);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= ACC_W'($signed(RST_VAL));
        end else begin
            acc_q <= acc_d;
        end
    end

    assign z_o = COORD_W'(sat_coord(SAT_W'(acc_q), COORD_W));

endmodule

// File: rtl/viewport_coord_gen.sv
// Raster walker: emits one saturated complex sample point per pixel on a ready/valid stream,
// with pan/zoom taken from shadow registers only at frame starts.
module viewport_coord_gen
    import pixgen_pkg::*;
#(
    parameter int unsigned WIDTH         = 640,
    parameter int unsigned HEIGHT        = 480,
    parameter int unsigned COORD_W       = 16,
    parameter int          DEF_ORIGIN_RE = PIX_DEF_ORIGIN_RE,
    parameter int          DEF_ORIGIN_IM = PIX_DEF_ORIGIN_IM,
    parameter int unsigned DEF_STEP      = PIX_DEF_STEP
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               run,
    input  logic               cfg_wr,
    input  logic [COORD_W-1:0] cfg_origin_re,
    input  logic [COORD_W-1:0] cfg_origin_im,
    input  logic [COORD_W-1:0] cfg_step,
    input  logic               ready,
    output logic               valid,
    output logic [COORD_W-1:0] z_re,
    output logic [COORD_W-1:0] z_im,
    output logic               first,
    output logic               lastx,
    output logic               frame_done,
    output logic               busy
);

    localparam int unsigned MAX_DIM = (WIDTH > HEIGHT) ? WIDTH : HEIGHT;
    localparam int unsigned ACC_W   = COORD_W + $clog2(MAX_DIM) + 1;
    localparam int unsigned X_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned Y_W     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [X_W-1:0]     X_LAST   = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]     Y_LAST   = Y_W'(HEIGHT - 1);
    localparam logic               LASTX_X0 = (X_LAST == '0);
    localparam logic [COORD_W-1:0] RST_ORE  = COORD_W'(DEF_ORIGIN_RE);
    localparam logic [COORD_W-1:0] RST_OIM  = COORD_W'(DEF_ORIGIN_IM);
    localparam logic [COORD_W-1:0] RST_STEP = COORD_W'(DEF_STEP);

    state_e             state_q;
    logic [X_W-1:0]     x_q;
    logic [Y_W-1:0]     y_q;
    logic               valid_q;
    logic               first_q;
    logic               lastx_q;
    logic               frame_done_q;
    logic               busy_q;
    logic [COORD_W-1:0] shd_ore_q;
    logic [COORD_W-1:0] shd_oim_q;
    logic [COORD_W-1:0] shd_step_q;
    logic [COORD_W-1:0] act_ore_q;
    logic [COORD_W-1:0] act_step_q;

    logic [COORD_W-1:0] shd_ore_d;
    logic [COORD_W-1:0] shd_oim_d;
    logic [COORD_W-1:0] shd_step_d;
    logic [X_W-1:0]     x_d;
    logic               accept;
    logic               eol;
    logic               eof;
    logic               start;
    logic               re_load;
    logic               re_step;
    logic               im_step;
    logic [COORD_W-1:0] re_load_val;

    // A cfg write landing on the frame-start edge is forwarded straight into the load.
    always_comb begin
        shd_ore_d   = cfg_wr ? cfg_origin_re : shd_ore_q;
        shd_oim_d   = cfg_wr ? cfg_origin_im : shd_oim_q;
        shd_step_d  = cfg_wr ? cfg_step      : shd_step_q;
        accept      = valid_q && ready;
        eol         = (x_q == X_LAST);
        eof         = eol && (y_q == Y_LAST);
        start       = (state_q == IDLE) ? run : (accept && eof && run);
        x_d         = eol ? '0 : (x_q + X_W'(1));
        re_load     = start || (accept && eol && !eof);
        re_load_val = start ? shd_ore_d : act_ore_q;
        re_step     = accept && !eol;
        im_step     = accept && eol && !eof;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            valid_q      <= 1'b0;
            first_q      <= 1'b0;
            lastx_q      <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            shd_ore_q    <= RST_ORE;
            shd_oim_q    <= RST_OIM;
            shd_step_q   <= RST_STEP;
            act_ore_q    <= RST_ORE;
            act_step_q   <= RST_STEP;
        end else begin
            shd_ore_q    <= shd_ore_d;
            shd_oim_q    <= shd_oim_d;
            shd_step_q   <= shd_step_d;
            frame_done_q <= accept && eof;
            if (start) begin
                state_q    <= RUN;
                busy_q     <= 1'b1;
                valid_q    <= 1'b1;
                first_q    <= 1'b1;
                lastx_q    <= LASTX_X0;
                x_q        <= '0;
                y_q        <= '0;
                act_ore_q  <= shd_ore_d;
                act_step_q <= shd_step_d;
            end else if (accept) begin
                first_q <= 1'b0;
                if (!eol) begin
                    x_q     <= x_d;
                    lastx_q <= (x_d == X_LAST);
                end else if (!eof) begin
                    x_q     <= '0;
                    y_q     <= y_q + Y_W'(1);
                    lastx_q <= LASTX_X0;
                end else begin
                    // Frame finished with run low: park until run is seen again.
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    lastx_q <= 1'b0;
                    x_q     <= '0;
                    y_q     <= '0;
                end
            end
        end
    end

    coord_accum #(
        .COORD_W  (COORD_W),
        .ACC_W    (ACC_W),
        .SUBTRACT (1'b0),
        .RST_VAL  (RST_ORE)
    ) u_re_axis (
        .clk_i      (aclk),
        .rst_i      (areset),
        .load_i     (re_load),
        .step_en_i  (re_step),
        .load_val_i (re_load_val),
        .step_i     (act_step_q),
        .z_o        (z_re)
    );

    coord_accum #(
        .COORD_W  (COORD_W),
        .ACC_W    (ACC_W),
        .SUBTRACT (1'b1),
        .RST_VAL  (RST_OIM)
    ) u_im_axis (
        .clk_i      (aclk),
        .rst_i      (areset),
        .load_i     (start),
        .step_en_i  (im_step),
        .load_val_i (shd_oim_d),
        .step_i     (act_step_q),
        .z_o        (z_im)
    );

    assign valid      = valid_q;
    assign first      = first_q;
    assign lastx      = lastx_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_viewport_coord_gen.sv
// Directed bench for viewport_coord_gen on a 4x3 raster with origin (-2,1) and step 1.
module tb_viewport_coord_gen;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int CW = 16;

    logic          aclk;
    logic          areset;
    logic          run;
    logic          cfg_wr;
    logic [CW-1:0] cfg_origin_re;
    logic [CW-1:0] cfg_origin_im;
    logic [CW-1:0] cfg_step;
    logic          ready;
    logic          valid;
    logic [CW-1:0] z_re;
    logic [CW-1:0] z_im;
    logic          first;
    logic          lastx;
    logic          frame_done;
    logic          busy;

    int n_vec    = 0;
    int n_err    = 0;
    int frame_no = 0;

    viewport_coord_gen #(
        .WIDTH         (W),
        .HEIGHT        (H),
        .COORD_W       (CW),
        .DEF_ORIGIN_RE (-2),
        .DEF_ORIGIN_IM (1),
        .DEF_STEP      (1)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .run           (run),
        .cfg_wr        (cfg_wr),
        .cfg_origin_re (cfg_origin_re),
        .cfg_origin_im (cfg_origin_im),
        .cfg_step      (cfg_step),
        .ready         (ready),
        .valid         (valid),
        .z_re          (z_re),
        .z_im          (z_im),
        .first         (first),
        .lastx         (lastx),
        .frame_done    (frame_done),
        .busy          (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Expected beat b of a frame with origin (ore, oim) and step st.
    task automatic check_beat(input int b, input int ore, input int oim, input int st);
        int x;
        int y;
        x = b % W;
        y = b / W;
        check($sformatf("f%0d b%0d valid", frame_no, b), 32'(valid), 1);
        check($sformatf("f%0d b%0d z_re", frame_no, b), $signed(z_re), clamp16(ore + x * st));
        check($sformatf("f%0d b%0d z_im", frame_no, b), $signed(z_im), clamp16(oim - y * st));
        check($sformatf("f%0d b%0d first", frame_no, b), 32'(first), (b == 0) ? 1 : 0);
        check($sformatf("f%0d b%0d lastx", frame_no, b), 32'(lastx), (x == W - 1) ? 1 : 0);
    endtask

    task automatic run_frame(input int ore, input int oim, input int st, input bit stall,
                             input int cfg_beat, input int cr, input int ci, input int cs,
                             input int drop_beat);
        for (int b = 0; b < W * H; b++) begin
            if (stall) begin
                ready = 1'b0;
                check_beat(b, ore, oim, st);
                step();
                check_beat(b, ore, oim, st);
                check($sformatf("f%0d b%0d stall frame_done", frame_no, b), 32'(frame_done), 0);
            end
            ready = 1'b1;
            check_beat(b, ore, oim, st);
            if (b == cfg_beat) begin
                cfg_wr        = 1'b1;
                cfg_origin_re = CW'(cr);
                cfg_origin_im = CW'(ci);
                cfg_step      = CW'(cs);
            end
            if (b == drop_beat) run = 1'b0;
            step();
            cfg_wr = 1'b0;
            check($sformatf("f%0d b%0d frame_done", frame_no, b), 32'(frame_done), (b == W * H - 1) ? 1 : 0);
        end
        frame_no++;
    endtask

    initial begin
        areset        = 1'b1;
        run           = 1'b0;
        ready         = 1'b0;
        cfg_wr        = 1'b0;
        cfg_origin_re = '0;
        cfg_origin_im = '0;
        cfg_step      = '0;
        step();
        step();
        check("rst valid", 32'(valid), 0);
        check("rst first", 32'(first), 0);
        check("rst lastx", 32'(lastx), 0);
        check("rst frame_done", 32'(frame_done), 0);
        check("rst busy", 32'(busy), 0);

        areset = 1'b0;
        step();
        check("idle valid", 32'(valid), 0);
        run = 1'b1;
        step();
        check("start busy", 32'(busy), 1);

        // Plain frame, then a frame with ready toggling every cycle.
        run_frame(-2, 1, 1, 1'b0, -1, 0, 0, 0, -1);
        run_frame(-2, 1, 1, 1'b1, -1, 0, 0, 0, -1);
        // Mid-frame cfg write only takes effect on the following frame.
        run_frame(-2, 1, 1, 1'b0, 5, 100, 0, 10, -1);
        run_frame(100, 0, 10, 1'b0, 0, 32760, 0, 5, -1);
        // Saturating frame; cfg write on the frame-boundary edge is bypassed into the load.
        run_frame(32760, 0, 5, 1'b0, 11, -2, 1, 1, -1);
        // run dropped mid-frame: frame still completes.
        run_frame(-2, 1, 1, 1'b0, -1, 0, 0, 0, 4);
        check("stop valid", 32'(valid), 0);
        check("stop busy", 32'(busy), 0);
        check("stop first", 32'(first), 0);
        step();
        step();
        check("parked valid", 32'(valid), 0);
        run = 1'b1;
        step();
        check_beat(0, -2, 1, 1);
        check("restart busy", 32'(busy), 1);

        // Async reset while stalled, with a non-default cfg sitting in the shadow registers.
        ready         = 1'b0;
        cfg_wr        = 1'b1;
        cfg_origin_re = CW'(50);
        cfg_origin_im = CW'(50);
        cfg_step      = CW'(3);
        step();
        cfg_wr = 1'b0;
        check_beat(0, -2, 1, 1);
        #3;
        areset = 1'b1;
        #1;
        check("async rst valid", 32'(valid), 0);
        check("async rst busy", 32'(busy), 0);
        check("async rst first", 32'(first), 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        ready  = 1'b1;
        step();
        frame_no++;
        check_beat(0, -2, 1, 1);
        step();
        check_beat(1, -2, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
